mc_sequencer: RTL

- Multicycle control sequencer for the MIPS-subset datapath: PC, instruction memory, register file, ALU, shifter, data memory.
- Replaces single-cycle combinational control. Each instruction is stepped through IF/ID/EX/MEM/WB.
- Instruction and data memories are handshaked (req/ack), so variable-latency memories can be used.
- Emits the same control set the datapath muxes already consume, plus PC and IR write enables.

---
 rtl/mc_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle IF/ID/EX/MEM/WB control for the MIPS-subset datapath.
// Optional cycle/retired-instruction counters are enabled with `define MC_PERF_CNT_EN.
//
// state | meaning
// IDLE  | waiting for run
// IF    | instruction fetch, imem handshake, IR load on ack
// ID    | register read, illegal-instruction check
// EX    | ALU op; branches/jumps update PC and finish here
// MEM   | data memory handshake (lw/sw)
// WB    | register write-back and PC+4
// HALT  | stopped until reset (err shows why)
module mc_sequencer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       pcrst,
  input  logic       run,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  input  logic       dmem_ack,
  output logic       Irwrite,
  output logic       Pcwrite,
  output logic       Wreg,
  output logic       Wmem,
  output logic       Regrt,
  output logic       Se,
  output logic       Aluqb,
  output logic [1:0] Aluc,
  output logic [1:0] Pcsrc,
  output logic [1:0] Reg2reg,
  output logic       Reglui,
  output logic       sArith,
  output logic       sRight,
  output logic       halted,
  output logic       err,
  output logic [2:0] state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
    S_MEM  = 3'd4, S_WB = 3'd5, S_HALT = 3'd7
  } state_t;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  state_t        state_q, state_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic       legal, is_beq, is_bne, is_j, is_jr, is_lw, is_sw;
  logic       d_regrt, d_se, d_aluqb, d_lui, d_sarith, d_sright;
  logic [1:0] d_aluc, d_r2r;
  logic       wait_st, tmo_hit;

  always_comb begin
    legal = 1'b0; is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0;
    is_jr = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
    d_regrt = 1'b0; d_se = 1'b0; d_aluqb = 1'b0; d_lui = 1'b0;
    d_sarith = 1'b0; d_sright = 1'b0; d_aluc = 2'b00; d_r2r = 2'b00;
    case (op)
      6'b000000: begin
        case (func)
          6'b100000: begin legal = 1'b1; d_aluqb = 1'b1; d_r2r = 2'b01; end
          6'b100010: begin legal = 1'b1; d_aluqb = 1'b1; d_r2r = 2'b01; d_aluc = 2'b01; end
          6'b100100: begin legal = 1'b1; d_aluqb = 1'b1; d_r2r = 2'b01; d_aluc = 2'b10; end
          6'b100101: begin legal = 1'b1; d_aluqb = 1'b1; d_r2r = 2'b01; d_aluc = 2'b11; end
          6'b000000: begin legal = 1'b1; d_r2r = 2'b10; end
          6'b000010: begin legal = 1'b1; d_r2r = 2'b10; d_sright = 1'b1; end
          6'b000011: begin legal = 1'b1; d_r2r = 2'b10; d_sright = 1'b1; d_sarith = 1'b1; end
          6'b001000: begin legal = 1'b1; is_jr = 1'b1; end
          default: ;
        endcase
      end
      6'b001000: begin legal = 1'b1; d_regrt = 1'b1; d_se = 1'b1; d_r2r = 2'b01; end
      6'b001100: begin legal = 1'b1; d_regrt = 1'b1; d_aluc = 2'b10; d_r2r = 2'b01; end
      6'b001101: begin legal = 1'b1; d_regrt = 1'b1; d_aluc = 2'b11; d_r2r = 2'b01; end
      6'b100011: begin legal = 1'b1; d_regrt = 1'b1; d_se = 1'b1; is_lw = 1'b1; end
      6'b101011: begin legal = 1'b1; d_regrt = 1'b1; d_se = 1'b1; is_sw = 1'b1; end
      6'b000100: begin legal = 1'b1; d_regrt = 1'b1; d_se = 1'b1; d_aluqb = 1'b1;
                       d_aluc = 2'b01; is_beq = 1'b1; end
      6'b000101: begin legal = 1'b1; d_regrt = 1'b1; d_se = 1'b1; d_aluqb = 1'b1;
                       d_aluc = 2'b01; is_bne = 1'b1; end
      6'b001111: begin legal = 1'b1; d_regrt = 1'b1; d_lui = 1'b1; d_r2r = 2'b01; end
      6'b000010: begin legal = 1'b1; is_j = 1'b1; end
      default: ;
    endcase
  end

  // A fetch with run low is abandoned, so it neither requests nor counts as waiting.
  assign wait_st = ((state_q == S_IF) && run && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);
  assign tmo_hit = (ACK_TIMEOUT != 0) && wait_st && (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    tmo_d   = (wait_st && !tmo_hit) ? tmo_q + TW'(1) : '0;
    case (state_q)
      S_IDLE: if (run) state_d = S_IF;
      S_IF: begin
        if (!run)          state_d = S_IDLE;
        else if (imem_ack) state_d = S_ID;
        else if (tmo_hit)  begin state_d = S_HALT; err_d = 1'b1; end
      end
      S_ID: begin
        if (legal) state_d = S_EX;
        else       begin state_d = S_HALT; err_d = 1'b1; end
      end
      S_EX: begin
        if (is_beq || is_bne || is_j || is_jr) state_d = S_IF;
        else if (is_lw || is_sw)               state_d = S_MEM;
        else                                   state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)     state_d = is_sw ? S_IF : S_WB;
        else if (tmo_hit) begin state_d = S_HALT; err_d = 1'b1; end
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    imem_req = 1'b0; dmem_req = 1'b0; Irwrite = 1'b0; Pcwrite = 1'b0;
    Wreg = 1'b0; Wmem = 1'b0; Regrt = 1'b0; Se = 1'b0; Aluqb = 1'b0;
    Aluc = 2'b00; Pcsrc = 2'b00; Reg2reg = 2'b00; Reglui = 1'b0;
    sArith = 1'b0; sRight = 1'b0;
    if (state_q == S_ID || state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
      Regrt = d_regrt; Se = d_se; Aluqb = d_aluqb; Aluc = d_aluc;
      Reg2reg = d_r2r; Reglui = d_lui; sArith = d_sarith; sRight = d_sright;
    end
    case (state_q)
      S_IF: begin
        imem_req = run;
        Irwrite  = run && imem_ack;
      end
      S_EX: begin
        if (is_beq || is_bne) begin
          Pcwrite = 1'b1;
          Pcsrc   = ((is_beq && z) || (is_bne && !z)) ? 2'b10 : 2'b00;
        end else if (is_j) begin
          Pcwrite = 1'b1; Pcsrc = 2'b11;
        end else if (is_jr) begin
          Pcwrite = 1'b1; Pcsrc = 2'b01;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        Aluc = 2'b00; Aluqb = 1'b0; Se = 1'b1;
        Wmem    = is_sw;
        Pcwrite = is_sw && dmem_ack;
      end
      S_WB: begin
        Wreg = 1'b1; Pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = (state_q == S_HALT);
  assign err    = err_q;
  assign state  = state_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, inst_q;

  always_ff @(posedge clk or negedge pcrst) begin
    if (!pcrst) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) cyc_q <= cyc_q + CNT_W'(1);
      if (Pcwrite) inst_q <= inst_q + CNT_W'(1);
    end
  end

  assign cyc_cnt     = cyc_q;
  assign instret_cnt = inst_q;
`endif

endmodule
